mul_rs: RTL and testbench
=========================

Name: mul_rs

Overview:
- Reservation station for the multiply functional unit in the Tomasulo core.
- Accepts issued multiply ops and holds their operands until both are valid.
- Captures operands broadcast on the common data bus (CDB).
- Dispatches one ready op at a time into the multiply pipeline. It also records the destination tag of the op in flight, so the multiplier result is broadcast with that tag.

Parameters:
- NUM_ENTRIES, 3, number of station slots (1..8).
- TAG_W, 4, tag width. Tag value 0 means "operand valid / no producer".

Ports:
- clk  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- issueEN  in  1  issue request from decode.
- issueQj  in  TAG_W  producer tag of operand 1 (0 = issueVj valid).
- issueVj  in  32  operand 1 value.
- issueQk  in  TAG_W  producer tag of operand 2 (0 = issueVk valid).
- issueVk  in  32  operand 2 value.
- issueTag  in  TAG_W  destination tag of the issued op; must be non-zero.
- full  out  1  all slots busy; issue is refused.
- count  out  4  number of busy slots.
- cdbValid  in  1  CDB broadcast valid.
- cdbTag  in  TAG_W  CDB producer tag.
- cdbData  in  32  CDB value.
- aluAvailable  in  1  multiplier can accept an op this cycle (the multiply state unit's available).
- aluWEN  out  1  dispatch strobe to the multiplier.
- aluData1  out  32  operand 1 of the dispatched op.
- aluData2  out  32  operand 2 of the dispatched op.
- resultTag  out  TAG_W  destination tag of the most recently dispatched op.

Behaviour:
- Per-slot state: busy, Qj, Vj, Qk, Vk, dest.
- A slot is ready when busy && Qj==0 && Qk==0.
- Reset (RST high at clock edge): all slots not busy, all fields 0, resultTag=0, count=0. Consequently full=0, aluWEN=0, aluData1=aluData2=0.
- RST overrides issue, CDB capture and dispatch in the same cycle. Ops in flight are discarded.
- Issue:
  - When issueEN && !full, the lowest-index non-busy slot (as of the start of the cycle) loads the op and sets busy.
  - When issueEN && full, the request is ignored and no state changes.
- Issue-time CDB capture: if cdbValid and cdbTag==issueQj (non-zero), the slot stores Vj=cdbData and Qj=0 at issue. Operand 2 is handled the same way against issueQk.
- CDB snoop:
  - Each cycle with cdbValid && cdbTag!=0, every busy slot with Qj==cdbTag loads Vj=cdbData and clears Qj.
  - The same applies independently to Qk/Vk.
  - A single broadcast may satisfy both operands of one slot and operands in several slots.
  - cdbTag==0 is ignored.
- Dispatch (combinational select, registered effect):
  - Selection: the lowest-index ready slot, using registered state only. There is no same-cycle CDB bypass; a slot woken by the CDB dispatches no earlier than the following cycle.
  - aluWEN = aluAvailable && any slot ready.
  - aluData1/aluData2 = Vj/Vk of the selected slot, or 0 if none is selected.
  - On a clock edge with aluWEN=1, the selected slot clears busy and resultTag loads its dest.
  - resultTag holds its value until the next dispatch.
- Simultaneous dispatch and issue: the slot freed by dispatch is not reusable in the same cycle.
  - If only that slot was free, issue succeeds only if full was 0 at the start of the cycle.
  - count = previous count + issued − dispatched.
- full = (count == NUM_ENTRIES), derived from registered busy bits.
- Ordering: none beyond index priority; software-visible ordering is the reorder logic's job.

Test Plan:
1. Reset, then issue Qj=0,Vj=6,Qk=0,Vk=7,tag=3 with aluAvailable=1. Next cycle: aluWEN=1, aluData1=6, aluData2=7. After that edge: resultTag=3, count=0.
2. Issue Qj=5,Vk=9,Qk=0,tag=2, then cdbValid with tag 5, data 11 two cycles later. aluWEN stays 0 until the cycle after the broadcast, then aluData1=11, aluData2=9.
3. Issue with issueQj=4 while cdbValid, cdbTag=4, cdbData=0x100 in the same cycle. The slot captures Vj=0x100, Qj=0, and the op dispatches next cycle.
4. Fill 3 slots with Qj=7 and aluAvailable=1: full=1, count=3. A fourth issue is ignored. Broadcast tag 7 wakes all three. They dispatch over 3 cycles in order slot0, slot1, slot2, and count falls 3→2→1→0.
5. Two ready slots with aluAvailable=0 for 4 cycles: aluWEN=0 and no state change. Raise aluAvailable: slot0 dispatches first.
6. Assert RST while 2 slots are busy and a dispatch is pending. After the edge: count=0, full=0, aluWEN=0, resultTag=0. A later CDB broadcast causes no dispatch.

Source files
------------

// File: rtl/mul_rs.sv
// Reservation station for the multiply unit: holds issued ops until both operands
// arrive (directly or via CDB snoop), then dispatches the lowest ready slot.
module mul_rs #(
    parameter int NUM_ENTRIES = 3,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             issueEN,
    input  logic [TAG_W-1:0] issueQj,
    input  logic [31:0]      issueVj,
    input  logic [TAG_W-1:0] issueQk,
    input  logic [31:0]      issueVk,
    input  logic [TAG_W-1:0] issueTag,
    output logic             full,
    output logic [3:0]       count,
    input  logic             cdbValid,
    input  logic [TAG_W-1:0] cdbTag,
    input  logic [31:0]      cdbData,
    input  logic             aluAvailable,
    output logic             aluWEN,
    output logic [31:0]      aluData1,
    output logic [31:0]      aluData2,
    output logic [TAG_W-1:0] resultTag
);
    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef struct packed {
        logic             busy;
        logic [TAG_W-1:0] qj;
        logic [31:0]      vj;
        logic [TAG_W-1:0] qk;
        logic [31:0]      vk;
        logic [TAG_W-1:0] dest;
    } slot_t;

    slot_t            slot_q [NUM_ENTRIES];
    slot_t            slot_d [NUM_ENTRIES];
    logic [TAG_W-1:0] result_tag_q, result_tag_d;

    logic             any_ready;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] free_idx;
    logic [3:0]       busy_cnt;
    logic             issue_ok;
    logic             cdb_hit;
    slot_t            issue_slot;

    // Scan from the top down so the lowest matching index is the one left standing.
    // NOTE: every combinational output gets a default before any conditional
    // assignment, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        any_ready = 1'b0;
        sel_idx   = '0;
        free_idx  = '0;
        busy_cnt  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (slot_q[i].busy && slot_q[i].qj == '0 && slot_q[i].qk == '0) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!slot_q[i].busy) begin
                free_idx = IDX_W'(i);
            end
            busy_cnt = busy_cnt + 4'(slot_q[i].busy);
        end
    end

    assign count     = busy_cnt;
    assign full      = (busy_cnt == 4'(NUM_ENTRIES));
    assign aluWEN    = aluAvailable && any_ready;
    assign aluData1  = any_ready ? slot_q[sel_idx].vj : 32'd0;
    assign aluData2  = any_ready ? slot_q[sel_idx].vk : 32'd0;
    assign resultTag = result_tag_q;

    assign issue_ok = issueEN && !full;
    assign cdb_hit  = cdbValid && (cdbTag != '0);

    // An operand whose producer is broadcasting right now is captured at issue.
    always_comb begin
        issue_slot      = '0;
        issue_slot.busy = 1'b1;
        issue_slot.dest = issueTag;
        issue_slot.qj   = issueQj;
        issue_slot.vj   = issueVj;
        issue_slot.qk   = issueQk;
        issue_slot.vk   = issueVk;
        if (cdb_hit && cdbTag == issueQj) begin
            issue_slot.qj = '0;
            issue_slot.vj = cdbData;
        end
        if (cdb_hit && cdbTag == issueQk) begin
            issue_slot.qk = '0;
            issue_slot.vk = cdbData;
        end
    end

    always_comb begin
        result_tag_d = result_tag_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            slot_d[i] = slot_q[i];
            if (slot_q[i].busy && cdb_hit) begin
                if (slot_q[i].qj == cdbTag) begin
                    slot_d[i].qj = '0;
                    slot_d[i].vj = cdbData;
                end
                if (slot_q[i].qk == cdbTag) begin
                    slot_d[i].qk = '0;
                    slot_d[i].vk = cdbData;
                end
            end
            // Free slot is chosen from start-of-cycle busy bits, so it never
            // coincides with the slot being dispatched this cycle.
            if (aluWEN && sel_idx == IDX_W'(i)) begin
                slot_d[i].busy = 1'b0;
            end
            if (issue_ok && free_idx == IDX_W'(i)) begin
                slot_d[i] = issue_slot;
            end
        end
        if (aluWEN) begin
            result_tag_d = slot_q[sel_idx].dest;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (RST) begin
            // NOTE: slot storage is reset as well, not just the busy bits, because
            // every field must read as zero after reset.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
            result_tag_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            result_tag_q <= result_tag_d;
        end
    end
endmodule

// File: tb/tb_mul_rs.sv
// Scoreboard bench for mul_rs: a behavioural slot model predicts dispatches and
// occupancy; a negedge monitor compares every dispatch strobe against the queue.
module tb_mul_rs;
    localparam int N  = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          issueEN = 1'b0;
    logic [TW-1:0] issueQj = '0, issueQk = '0, issueTag = '0;
    logic [31:0]   issueVj = '0, issueVk = '0;
    logic          full;
    logic [3:0]    count;
    logic          cdbValid = 1'b0;
    logic [TW-1:0] cdbTag = '0;
    logic [31:0]   cdbData = '0;
    logic          aluAvailable = 1'b0;
    logic          aluWEN;
    logic [31:0]   aluData1, aluData2;
    logic [TW-1:0] resultTag;

    always #5 clk = ~clk;

    mul_rs #(.NUM_ENTRIES(N), .TAG_W(TW)) dut (
        .clk(clk), .RST(RST),
        .issueEN(issueEN), .issueQj(issueQj), .issueVj(issueVj),
        .issueQk(issueQk), .issueVk(issueVk), .issueTag(issueTag),
        .full(full), .count(count),
        .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbData(cdbData),
        .aluAvailable(aluAvailable), .aluWEN(aluWEN),
        .aluData1(aluData1), .aluData2(aluData2), .resultTag(resultTag)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
    } disp_t;
    disp_t exp_q[$];

    // Reference model: one record per station slot, updated by the rules directly.
    typedef struct {
        bit          busy;
        bit [TW-1:0] qj;
        bit [31:0]   vj;
        bit [TW-1:0] qk;
        bit [31:0]   vk;
        bit [TW-1:0] dest;
    } op_t;
    op_t         m_slot[N];
    bit [TW-1:0] m_rtag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_slot[i].busy) c++;
        return c;
    endfunction

    // One clock cycle: drive inputs, predict, advance the model, check occupancy.
    task automatic step(input bit r, input bit en,
                        input bit [TW-1:0] qj, input bit [31:0] vj,
                        input bit [TW-1:0] qk, input bit [31:0] vk,
                        input bit [TW-1:0] tag,
                        input bit cv, input bit [TW-1:0] ct, input bit [31:0] cd,
                        input bit av);
        int  sel = -1;
        int  free = -1;
        op_t nw;
        RST = r; issueEN = en; issueQj = qj; issueVj = vj; issueQk = qk;
        issueVk = vk; issueTag = tag; cdbValid = cv; cdbTag = ct; cdbData = cd;
        aluAvailable = av;
        for (int i = 0; i < N; i++) begin
            if (sel < 0 && m_slot[i].busy && m_slot[i].qj == 0 && m_slot[i].qk == 0) sel = i;
            if (free < 0 && !m_slot[i].busy) free = i;
        end
        if (!r && av && sel >= 0) exp_q.push_back('{m_slot[sel].vj, m_slot[sel].vk});
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) m_slot[i] = '{0, 0, 0, 0, 0, 0};
            m_rtag = 0;
        end else begin
            if (cv && ct != 0) begin
                for (int i = 0; i < N; i++) begin
                    if (m_slot[i].busy && m_slot[i].qj == ct) begin m_slot[i].qj = 0; m_slot[i].vj = cd; end
                    if (m_slot[i].busy && m_slot[i].qk == ct) begin m_slot[i].qk = 0; m_slot[i].vk = cd; end
                end
            end
            if (av && sel >= 0) begin
                m_slot[sel].busy = 0;
                m_rtag = m_slot[sel].dest;
            end
            if (en && free >= 0) begin
                nw = '{1, qj, vj, qk, vk, tag};
                if (cv && ct != 0 && ct == qj) begin nw.qj = 0; nw.vj = cd; end
                if (cv && ct != 0 && ct == qk) begin nw.qk = 0; nw.vk = cd; end
                m_slot[free] = nw;
            end
        end
        #1;
        check("count", count, m_count());
        check("full", full, (m_count() == N));
        check("resultTag", resultTag, m_rtag);
    endtask

    task automatic idle(input bit av);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, av);
    endtask

    task automatic issue(input bit [TW-1:0] qj, input bit [31:0] vj,
                         input bit [TW-1:0] qk, input bit [31:0] vk,
                         input bit [TW-1:0] tag, input bit av);
        step(0, 1, qj, vj, qk, vk, tag, 0, 0, 0, av);
    endtask

    task automatic cdb(input bit [TW-1:0] ct, input bit [31:0] cd, input bit av);
        step(0, 0, 0, 0, 0, 0, 0, 1, ct, cd, av);
    endtask

    // Monitor: every non-reset cycle, the strobe must match whether a dispatch
    // was predicted, and a dispatch must carry the predicted operands.
    always @(negedge clk) begin
        disp_t e;
        if (RST !== 1'b1) begin
            check("aluWEN", {31'd0, aluWEN}, {31'd0, (exp_q.size() != 0)});
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (aluWEN === 1'b1) begin
                    check("aluData1", aluData1, e.d1);
                    check("aluData2", aluData2, e.d2);
                end
            end
        end
    end

    initial begin
        bit          r_en, r_cv, r_av, r_rst;
        bit [TW-1:0] r_qj, r_qk, r_tag, r_ct;
        bit [31:0]   r_vj, r_vk, r_cd;

        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("reset_aluWEN", {31'd0, aluWEN}, 32'd0);
        check("reset_aluData1", aluData1, 32'd0);
        check("reset_aluData2", aluData2, 32'd0);

        // 1: ready op dispatches next cycle
        issue(0, 6, 0, 7, 3, 1);
        idle(1);
        check("t1_resultTag", resultTag, 32'd3);
        check("t1_count", count, 32'd0);

        // 2: wake-up by CDB, dispatch the cycle after the broadcast
        issue(5, 32'hdead, 0, 9, 2, 1);
        idle(1);
        idle(1);
        cdb(5, 11, 1);
        idle(1);
        check("t2_resultTag", resultTag, 32'd2);

        // 3: capture at issue
        step(0, 1, 4, 32'hbeef, 0, 2, 6, 1, 4, 32'h100, 1);
        idle(1);

        // 4: fill, refused fourth issue, broadcast wakes all three
        issue(7, 0, 0, 21, 1, 1);
        issue(7, 0, 0, 22, 2, 1);
        issue(7, 0, 0, 23, 3, 1);
        check("t4_full", full, 32'd1);
        issue(0, 1, 0, 1, 4, 1);
        check("t4_count_after_refuse", count, 32'd3);
        cdb(7, 32'h77, 1);
        idle(1);
        idle(1);
        idle(1);
        check("t4_last_tag", resultTag, 32'd3);

        // 5: stall with aluAvailable low
        issue(0, 30, 0, 31, 8, 0);
        issue(0, 40, 0, 41, 9, 0);
        for (int i = 0; i < 4; i++) idle(0);
        idle(1);
        check("t5_first_tag", resultTag, 32'd8);
        idle(1);

        // 6: reset discards pending work
        issue(0, 50, 0, 51, 10, 0);
        issue(9, 60, 0, 61, 11, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("t6_count", count, 32'd0);
        check("t6_resultTag", resultTag, 32'd0);
        cdb(9, 32'h99, 1);
        idle(1);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_en  = ($urandom_range(0, 2) != 0);
            r_qj  = ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 7)) : '0;
            r_qk  = ($urandom_range(0, 1) != 0) ? TW'($urandom_range(1, 7)) : '0;
            r_vj  = $urandom;
            r_vk  = $urandom;
            r_tag = TW'($urandom_range(1, 15));
            r_cv  = ($urandom_range(0, 1) != 0);
            r_ct  = TW'($urandom_range(0, 7));
            r_cd  = $urandom;
            r_av  = ($urandom_range(0, 3) != 0);
            step(r_rst, r_en, r_qj, r_vj, r_qk, r_vk, r_tag, r_cv, r_ct, r_cd, r_av);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
